rv_multicycle_core: RTL and testbench

- Synthesizable multi-cycle RV32 integer core executing the team's instruction subset: lh, sh, sub, or, andi, srl, beq, addi, plus ebreak as halt.
- Instructions are in standard RV32I binary encoding, fetched from an external instruction memory.
- Data accesses use a req/ack handshake to an external halfword data memory.
- Sits below the bench, which preloads the memories, pulses start and reads the register file back through a debug port.

---
 rtl/rv_multicycle_core.sv | 345 ++++++++++++++++++++++++++++++++++
 tb/tb_rv_multicycle_core.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_multicycle_core.sv
// rv_multicycle_core
//   Multi-cycle RV32 integer core for a small instruction subset:
//   lh, sh, sub, or, andi, srl, beq, addi, and ebreak, which halts the core.
//   Every instruction walks FETCH -> DECODE -> EXEC, then MEM and/or WB if it
//   needs them. Illegal encodings and misaligned data accesses halt the core
//   with the sticky illegal flag set.
//
// Optional build macro: RV_EXT_ALU_EN
//   When defined, the core also accepts add, and, xor, sll, sra, bne and
//   lw/sw, and the dmem data ports become 32 bits wide. When undefined, those
//   encodings are illegal and the dmem data ports are 16 bits wide.
//
// Ports
//   clk         core clock, rising edge
//   reset       asynchronous active-high reset, clears all state
//   start       one-cycle pulse, accepted only in IDLE or HALT
//   imem_addr   instruction word address (pc[IMEM_AW+1:2])
//   imem_rdata  instruction word, valid the cycle after imem_addr
//   dmem_req    data request, held until dmem_ack
//   dmem_we     1 = store, 0 = load
//   dmem_addr   data byte address
//   dmem_wdata  store data (low bits of rs2)
//   dmem_rdata  load data, valid with dmem_ack
//   dmem_ack    completes the pending data request
//   halted      core is in HALT
//   illegal     sticky illegal-instruction / misaligned-access flag
//   instret     retired instruction count
//   dbg_addr    register index for debug read
//   dbg_rdata   combinational register read, 0 for indices >= REG_COUNT
module rv_multicycle_core #(
    parameter int          REG_COUNT = 32,
    parameter logic [31:0] PC_RESET  = 32'h0000_0000,
    parameter int          IMEM_AW   = 10,
    parameter int          DMEM_AW   = 12
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_rdata,
    output logic               dmem_req,
    output logic               dmem_we,
    output logic [DMEM_AW-1:0] dmem_addr,
`ifdef RV_EXT_ALU_EN
    output logic [31:0]        dmem_wdata,
    input  logic [31:0]        dmem_rdata,
`else
    output logic [15:0]        dmem_wdata,
    input  logic [15:0]        dmem_rdata,
`endif
    input  logic               dmem_ack,
    output logic               halted,
    output logic               illegal,
    output logic [31:0]        instret,
    input  logic [4:0]         dbg_addr,
    output logic [31:0]        dbg_rdata
);

`ifdef RV_EXT_ALU_EN
    localparam int DW = 32;
`else
    localparam int DW = 16;
`endif
    localparam logic [31:0] REG_LIMIT = 32'(REG_COUNT);
    localparam logic [31:0] EBREAK    = 32'h0010_0073;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_t;

    typedef enum logic [3:0] {
        OP_ADDI, OP_ANDI, OP_SUB, OP_OR, OP_SRL, OP_BEQ, OP_LH, OP_SH,
        OP_ADD, OP_AND, OP_XOR, OP_SLL, OP_SRA, OP_BNE, OP_LW, OP_SW
    } op_t;

    state_t             state_reg, state_next;
    logic [31:0]        pc_reg;
    logic [31:0]        instret_reg;
    logic               illegal_reg;
    op_t                op_reg;
    logic [4:0]         rd_reg;
    logic [31:0]        rs1_reg, rs2_reg, imm_reg, result_reg;
    logic [DMEM_AW-1:0] addr_reg;
    logic [31:0]        regs [REG_COUNT];

    // ---------------- decode (operates on imem_rdata during DECODE) -------
    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    logic [4:0]  rd_f, rs1_f, rs2_f;
    logic [31:0] imm_i, imm_s, imm_b;
    logic [31:0] rs1_val, rs2_val, dec_imm;
    op_t         dec_op;
    logic        dec_legal, dec_rd_used, dec_rs1_used, dec_rs2_used;
    logic        dec_idx_ok, dec_ebreak;

    assign opcode = imem_rdata[6:0];
    assign rd_f   = imem_rdata[11:7];
    assign funct3 = imem_rdata[14:12];
    assign rs1_f  = imem_rdata[19:15];
    assign rs2_f  = imem_rdata[24:20];
    assign funct7 = imem_rdata[31:25];

    assign imm_i = {{20{imem_rdata[31]}}, imem_rdata[31:20]};
    assign imm_s = {{20{imem_rdata[31]}}, imem_rdata[31:25], imem_rdata[11:7]};
    assign imm_b = {{19{imem_rdata[31]}}, imem_rdata[31], imem_rdata[7],
                    imem_rdata[30:25], imem_rdata[11:8], 1'b0};

    assign rs1_val = ({27'd0, rs1_f} < REG_LIMIT) ? regs[rs1_f] : 32'd0;
    assign rs2_val = ({27'd0, rs2_f} < REG_LIMIT) ? regs[rs2_f] : 32'd0;

    always_comb begin
        dec_op       = OP_ADDI;
        dec_legal    = 1'b0;
        dec_imm      = imm_i;
        dec_rd_used  = 1'b0;
        dec_rs1_used = 1'b0;
        dec_rs2_used = 1'b0;
        case (opcode)
            7'b0010011: begin
                dec_rd_used  = 1'b1;
                dec_rs1_used = 1'b1;
                case (funct3)
                    3'b000:  begin dec_op = OP_ADDI; dec_legal = 1'b1; end
                    3'b111:  begin dec_op = OP_ANDI; dec_legal = 1'b1; end
                    default: ;
                endcase
            end
            7'b0110011: begin
                dec_rd_used  = 1'b1;
                dec_rs1_used = 1'b1;
                dec_rs2_used = 1'b1;
                case ({funct7, funct3})
                    10'b0100000_000: begin dec_op = OP_SUB; dec_legal = 1'b1; end
                    10'b0000000_110: begin dec_op = OP_OR;  dec_legal = 1'b1; end
                    10'b0000000_101: begin dec_op = OP_SRL; dec_legal = 1'b1; end
`ifdef RV_EXT_ALU_EN
                    10'b0000000_000: begin dec_op = OP_ADD; dec_legal = 1'b1; end
                    10'b0000000_111: begin dec_op = OP_AND; dec_legal = 1'b1; end
                    10'b0000000_100: begin dec_op = OP_XOR; dec_legal = 1'b1; end
                    10'b0000000_001: begin dec_op = OP_SLL; dec_legal = 1'b1; end
                    10'b0100000_101: begin dec_op = OP_SRA; dec_legal = 1'b1; end
`endif
                    default: ;
                endcase
            end
            7'b0000011: begin
                dec_rd_used  = 1'b1;
                dec_rs1_used = 1'b1;
                case (funct3)
                    3'b001:  begin dec_op = OP_LH; dec_legal = 1'b1; end
`ifdef RV_EXT_ALU_EN
                    3'b010:  begin dec_op = OP_LW; dec_legal = 1'b1; end
`endif
                    default: ;
                endcase
            end
            7'b0100011: begin
                dec_rs1_used = 1'b1;
                dec_rs2_used = 1'b1;
                dec_imm      = imm_s;
                case (funct3)
                    3'b001:  begin dec_op = OP_SH; dec_legal = 1'b1; end
`ifdef RV_EXT_ALU_EN
                    3'b010:  begin dec_op = OP_SW; dec_legal = 1'b1; end
`endif
                    default: ;
                endcase
            end
            7'b1100011: begin
                dec_rs1_used = 1'b1;
                dec_rs2_used = 1'b1;
                dec_imm      = imm_b;
                case (funct3)
                    3'b000:  begin dec_op = OP_BEQ; dec_legal = 1'b1; end
`ifdef RV_EXT_ALU_EN
                    3'b001:  begin dec_op = OP_BNE; dec_legal = 1'b1; end
`endif
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    // Only register fields the format actually uses are range-checked.
    assign dec_idx_ok = !(dec_rd_used  && ({27'd0, rd_f}  >= REG_LIMIT)) &&
                        !(dec_rs1_used && ({27'd0, rs1_f} >= REG_LIMIT)) &&
                        !(dec_rs2_used && ({27'd0, rs2_f} >= REG_LIMIT));
    assign dec_ebreak = (imem_rdata == EBREAK);

    // ---------------- execute (operates on latched operands) --------------
    logic [DMEM_AW-1:0] exec_addr;
    logic [31:0]        alu_result, load_value;
    logic               is_load, is_store, is_mem, is_word, is_branch;
    logic               misaligned, branch_taken;

    // Truncating before the add keeps the address at DMEM_AW bits.
    assign exec_addr = rs1_reg[DMEM_AW-1:0] + imm_reg[DMEM_AW-1:0];
    assign is_load   = (op_reg == OP_LH) || (op_reg == OP_LW);
    assign is_store  = (op_reg == OP_SH) || (op_reg == OP_SW);
    assign is_mem    = is_load || is_store;
    assign is_word   = (op_reg == OP_LW) || (op_reg == OP_SW);
    assign is_branch = (op_reg == OP_BEQ) || (op_reg == OP_BNE);
    assign misaligned = is_word ? (exec_addr[1:0] != 2'b00) : exec_addr[0];
    assign branch_taken = (op_reg == OP_BEQ) ? (rs1_reg == rs2_reg) : (rs1_reg != rs2_reg);

    always_comb begin
        alu_result = 32'd0;
        case (op_reg)
            OP_ADDI: alu_result = rs1_reg + imm_reg;
            OP_ADD:  alu_result = rs1_reg + rs2_reg;
            OP_SUB:  alu_result = rs1_reg - rs2_reg;
            OP_ANDI: alu_result = rs1_reg & imm_reg;
            OP_AND:  alu_result = rs1_reg & rs2_reg;
            OP_OR:   alu_result = rs1_reg | rs2_reg;
            OP_XOR:  alu_result = rs1_reg ^ rs2_reg;
            OP_SRL:  alu_result = rs1_reg >> rs2_reg[4:0];
            OP_SLL:  alu_result = rs1_reg << rs2_reg[4:0];
            OP_SRA:  alu_result = $unsigned($signed(rs1_reg) >>> rs2_reg[4:0]);
            default: alu_result = 32'd0;
        endcase
    end

`ifdef RV_EXT_ALU_EN
    assign load_value = (op_reg == OP_LW) ? dmem_rdata
                                          : {{16{dmem_rdata[15]}}, dmem_rdata[15:0]};
`else
    assign load_value = {{16{dmem_rdata[15]}}, dmem_rdata};
`endif

    // ---------------- FSM ---------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE, S_HALT: if (start) state_next = S_FETCH;
            S_FETCH:        state_next = S_DECODE;
            S_DECODE: begin
                // ebreak is outside the legal opcode set, so test it first.
                if (dec_ebreak)                     state_next = S_HALT;
                else if (!dec_legal || !dec_idx_ok) state_next = S_HALT;
                else                                state_next = S_EXEC;
            end
            S_EXEC: begin
                if (is_mem)         state_next = misaligned ? S_HALT : S_MEM;
                else if (is_branch) state_next = S_FETCH;
                else                state_next = S_WB;
            end
            S_MEM: if (dmem_ack) state_next = is_store ? S_FETCH : S_WB;
            S_WB:  state_next = S_FETCH;
            default: state_next = S_IDLE;
        endcase
    end

    // ---------------- datapath registers ------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_reg      <= PC_RESET;
            instret_reg <= 32'd0;
            illegal_reg <= 1'b0;
            op_reg      <= OP_ADDI;
            rd_reg      <= 5'd0;
            rs1_reg     <= 32'd0;
            rs2_reg     <= 32'd0;
            imm_reg     <= 32'd0;
            result_reg  <= 32'd0;
            addr_reg    <= '0;
        end else begin
            case (state_reg)
                S_IDLE, S_HALT: begin
                    if (start) begin
                        pc_reg      <= PC_RESET;
                        instret_reg <= 32'd0;
                        illegal_reg <= 1'b0;
                    end
                end
                S_DECODE: begin
                    op_reg  <= dec_op;
                    rd_reg  <= rd_f;
                    rs1_reg <= rs1_val;
                    rs2_reg <= rs2_val;
                    imm_reg <= dec_imm;
                    if (dec_ebreak)                     instret_reg <= instret_reg + 32'd1;
                    else if (!dec_legal || !dec_idx_ok) illegal_reg <= 1'b1;
                end
                S_EXEC: begin
                    result_reg <= alu_result;
                    addr_reg   <= exec_addr;
                    if (is_mem) begin
                        if (misaligned) illegal_reg <= 1'b1;
                    end else if (is_branch) begin
                        pc_reg      <= branch_taken ? (pc_reg + imm_reg) : (pc_reg + 32'd4);
                        instret_reg <= instret_reg + 32'd1;
                    end
                end
                S_MEM: begin
                    if (dmem_ack) begin
                        if (is_store) begin
                            pc_reg      <= pc_reg + 32'd4;
                            instret_reg <= instret_reg + 32'd1;
                        end else begin
                            result_reg <= load_value;
                        end
                    end
                end
                S_WB: begin
                    pc_reg      <= pc_reg + 32'd4;
                    instret_reg <= instret_reg + 32'd1;
                end
                default: ;
            endcase
        end
    end

    // Register file; x0 is never written so it always reads zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                regs[i] <= 32'd0;
            end
        end else if (state_reg == S_WB && rd_reg != 5'd0) begin
            regs[rd_reg] <= result_reg;
        end
    end

    // ---------------- outputs -----------------------------------------------
    assign imem_addr  = pc_reg[IMEM_AW+1:2];
    // Request is a pure decode of state so an async reset drops it at once.
    assign dmem_req   = (state_reg == S_MEM);
    assign dmem_we    = dmem_req && is_store;
    assign dmem_addr  = addr_reg;
    assign dmem_wdata = rs2_reg[DW-1:0];
    assign halted     = (state_reg == S_HALT);
    assign illegal    = illegal_reg;
    assign instret    = instret_reg;
    assign dbg_rdata  = ({27'd0, dbg_addr} < REG_LIMIT) ? regs[dbg_addr] : 32'd0;

endmodule

// File: tb/tb_rv_multicycle_core.sv
// Directed testbench for rv_multicycle_core: instruction memory with a
// one-cycle synchronous read, halfword data memory with a programmable ack
// delay, and hand-computed expected register/flag/cycle values.
module tb_rv_multicycle_core;

`ifdef RV_EXT_ALU_EN
    localparam int DW = 32;
`else
    localparam int DW = 16;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [9:0]    imem_addr;
    logic [31:0]   imem_rdata = 32'd0;
    logic          dmem_req, dmem_we, dmem_ack;
    logic [11:0]   dmem_addr;
    logic [DW-1:0] dmem_wdata, dmem_rdata;
    logic          halted, illegal;
    logic [31:0]   instret;
    logic [4:0]    dbg_addr = 5'd0;
    logic [31:0]   dbg_rdata;

    int tests_run    = 0;
    int tests_failed = 0;

    rv_multicycle_core dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_rdata (dmem_rdata),
        .dmem_ack   (dmem_ack),
        .halted     (halted),
        .illegal    (illegal),
        .instret    (instret),
        .dbg_addr   (dbg_addr),
        .dbg_rdata  (dbg_rdata)
    );

    always #5 clk = ~clk;

    // ---------------- memory models ----------------
    logic [31:0] imem [0:1023];
    logic [15:0] dmem [0:2047];

    always @(posedge clk) imem_rdata <= imem[imem_addr];

    int          ack_delay = 3;
    int          wait_cnt  = 0;
    int          wr_count  = 0;
    logic [11:0] wr_addr   = 12'd0;
    logic [15:0] wr_data   = 16'd0;

    assign dmem_ack   = dmem_req && (wait_cnt == ack_delay - 1);
    assign dmem_rdata = DW'(dmem[dmem_addr[11:1]]);

    always @(posedge clk) begin
        if (dmem_req && !dmem_ack) wait_cnt <= wait_cnt + 1;
        else                       wait_cnt <= 0;
        if (dmem_req && dmem_ack && dmem_we) begin
            dmem[dmem_addr[11:1]] = dmem_wdata[15:0];
            wr_count <= wr_count + 1;
            wr_addr  <= dmem_addr;
            wr_data  <= dmem_wdata[15:0];
        end
    end

    // Length of each request (in cycles, including the ack cycle).
    int req_total    = 0;
    int cur_len      = 0;
    int last_req_len = 0;
    always @(negedge clk) begin
        if (dmem_req) begin
            req_total++;
            cur_len++;
            if (dmem_ack) begin
                last_req_len = cur_len;
                cur_len      = 0;
            end
        end else begin
            cur_len = 0;
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s: 0x%08h", tag, got);
        end
    endtask

    task automatic check_reg(input string tag, input int idx, input logic [31:0] exp);
        dbg_addr = 5'(idx);
        #1;
        check(tag, dbg_rdata, exp);
    endtask

    function automatic logic [31:0] i_type(input logic [11:0] imm, input logic [4:0] rs1,
                                           input logic [2:0] f3, input logic [4:0] rd,
                                           input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] r_type(input logic [6:0] f7, input logic [4:0] rs2,
                                           input logic [4:0] rs1, input logic [2:0] f3,
                                           input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] sh_enc(input logic [11:0] imm, input logic [4:0] rs2,
                                           input logic [4:0] rs1);
        return {imm[11:5], rs2, rs1, 3'b001, imm[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] beq_enc(input logic [12:0] imm, input logic [4:0] rs2,
                                            input logic [4:0] rs1);
        return {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs1,
                                         input logic [11:0] imm);
        return i_type(imm, rs1, 3'b000, rd, 7'b0010011);
    endfunction

    function automatic logic [31:0] lh(input logic [4:0] rd, input logic [4:0] rs1,
                                       input logic [11:0] imm);
        return i_type(imm, rs1, 3'b001, rd, 7'b0000011);
    endfunction

    localparam logic [31:0] EBREAK = 32'h0010_0073;

    task automatic load_prog(input logic [31:0] prog[$]);
        for (int i = 0; i < 1024; i++) imem[i] = (i < prog.size()) ? prog[i] : 32'd0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    int trace [0:255];

    // Pulse start, then count clock edges after the accepting edge until
    // halted. Optionally pulse start again after edge poke_edge.
    task automatic run(input int budget, input int poke_edge, output int edges);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        edges = 0;
        trace[0] = int'(imem_addr);
        while (!halted && edges < budget) begin
            if (edges == poke_edge) start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
            edges++;
            if (edges < 256) trace[edges] = int'(imem_addr);
        end
        check("halt reached", {31'd0, halted}, 32'd1);
    endtask

    logic [31:0] prog [$];
    int edges, req_before, wr_before, n;

    initial begin
        for (int i = 0; i < 2048; i++) dmem[i] = 16'd0;
        dmem[8] = 16'h1234;   // byte address 16
        load_prog('{EBREAK});

        // ---------- reset state ----------
        repeat (3) @(posedge clk);
        #1;
        check("rst halted",    {31'd0, halted},   32'd0);
        check("rst illegal",   {31'd0, illegal},  32'd0);
        check("rst instret",   instret,           32'd0);
        check("rst dmem_req",  {31'd0, dmem_req}, 32'd0);
        check("rst imem_addr", {22'd0, imem_addr}, 32'd0);
        check_reg("rst x1", 1, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // ---------- P1: addi/addi/sub/ebreak, stray start mid-run ----------
        prog = '{32'h0050_0093, 32'h0030_0113, 32'h4020_81B3, EBREAK};
        load_prog(prog);
        run(200, 5, edges);
        // 3 ALU ops x 4 cycles + ebreak FETCH/DECODE = 14 edges to HALT.
        check("p1 cycles",  32'(edges), 32'd14);
        check_reg("p1 x3", 3, 32'd2);
        check_reg("p1 x1", 1, 32'd5);
        check("p1 illegal", {31'd0, illegal}, 32'd0);
        check("p1 instret", instret, 32'd4);

        // ---------- P2: andi / srl / or / sub ----------
        do_reset();
        prog = '{addi(1, 0, 12'hFFF),
                 i_type(12'd255, 1, 3'b111, 2, 7'b0010011),
                 addi(4, 0, 12'd4),
                 r_type(7'h00, 4, 1, 3'b101, 3),
                 addi(6, 0, 12'h100),
                 r_type(7'h00, 6, 2, 3'b110, 5),
                 r_type(7'h20, 4, 0, 3'b000, 7),
                 EBREAK};
        load_prog(prog);
        run(200, -1, edges);
        check_reg("p2 andi x2", 2, 32'h0000_00FF);
        check_reg("p2 srl x3",  3, 32'h0FFF_FFFF);
        check_reg("p2 or x5",   5, 32'h0000_01FF);
        check_reg("p2 sub x7",  7, 32'hFFFF_FFFC);
        check("p2 instret", instret, 32'd8);
        check("p2 cycles",  32'(edges), 32'd30);

        // ---------- P3: sh / lh with 3-cycle ack ----------
        do_reset();
        ack_delay = 3;
        prog = '{addi(5, 0, 12'hFFE), sh_enc(12'd8, 5, 0), lh(6, 0, 12'd8),
                 lh(7, 0, 12'd16), EBREAK};
        load_prog(prog);
        wr_before = wr_count;
        run(200, -1, edges);
        check("p3 wr count", 32'(wr_count - wr_before), 32'd1);
        check("p3 wr addr",  {20'd0, wr_addr}, 32'd8);
        check("p3 wr data",  {16'd0, wr_data}, 32'h0000_FFFE);
        check_reg("p3 lh x6", 6, 32'hFFFF_FFFE);
        check_reg("p3 lh x7", 7, 32'h0000_1234);
        check("p3 req len", 32'(last_req_len), 32'd3);
        // addi 4 + sh 6 + lh 7 + lh 7 + ebreak 2
        check("p3 cycles",  32'(edges), 32'd26);
        check("p3 instret", instret, 32'd5);

        // ---------- P4: beq taken / not taken ----------
        do_reset();
        prog = '{beq_enc(13'd8, 0, 0), addi(7, 0, 12'd1), addi(1, 0, 12'd1),
                 addi(2, 0, 12'd2), beq_enc(13'd8, 2, 1), addi(8, 0, 12'd3), EBREAK};
        load_prog(prog);
        run(200, -1, edges);
        check_reg("p4 skipped x7", 7, 32'd0);
        check_reg("p4 fallthru x8", 8, 32'd3);
        check("p4 fetch after taken",  32'(trace[3]),  32'd2);
        check("p4 fetch after ntaken", 32'(trace[14]), 32'd5);
        check("p4 cycles",  32'(edges), 32'd20);
        check("p4 instret", instret, 32'd6);

        // ---------- P5: misaligned lh ----------
        do_reset();
        load_prog('{lh(1, 0, 12'd1), EBREAK});
        req_before = req_total;
        run(200, -1, edges);
        check("p5 illegal", {31'd0, illegal}, 32'd1);
        check("p5 no req",  32'(req_total - req_before), 32'd0);
        check("p5 instret", instret, 32'd0);
        check("p5 cycles",  32'(edges), 32'd3);

        // ---------- P6: write to x0 ----------
        load_prog('{addi(0, 0, 12'd9), EBREAK});
        run(200, -1, edges);
        check_reg("p6 x0", 0, 32'd0);
        check("p6 illegal", {31'd0, illegal}, 32'd0);
        check("p6 instret", instret, 32'd2);

        // ---------- P7: extension encoding (xor) ----------
        load_prog('{r_type(7'h00, 3, 2, 3'b100, 1), EBREAK});
        run(200, -1, edges);
`ifdef RV_EXT_ALU_EN
        check("p7 xor illegal", {31'd0, illegal}, 32'd0);
        check("p7 instret",     instret, 32'd2);
`else
        check("p7 xor illegal", {31'd0, illegal}, 32'd1);
        check("p7 instret",     instret, 32'd0);
`endif

        // ---------- P8: reset during a pending access, then rerun ----------
        do_reset();
        ack_delay = 50;
        prog = '{addi(5, 0, 12'hFFE), sh_enc(12'd8, 5, 0), lh(6, 0, 12'd8),
                 lh(7, 0, 12'd16), EBREAK};
        load_prog(prog);
        dmem[4] = 16'd0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        n = 0;
        while (!dmem_req && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("p8 req pending", {31'd0, dmem_req}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("p8 async req",     {31'd0, dmem_req}, 32'd0);
        check("p8 async we",      {31'd0, dmem_we},  32'd0);
        check("p8 async instret", instret,           32'd0);
        check("p8 async imem",    {22'd0, imem_addr}, 32'd0);
        check("p8 async addr",    {20'd0, dmem_addr}, 32'd0);
        check_reg("p8 async x5", 5, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        ack_delay = 3;
        run(200, -1, edges);
        check_reg("p8 rerun x6", 6, 32'hFFFF_FFFE);
        check("p8 rerun instret", instret, 32'd5);
        check("p8 rerun illegal", {31'd0, illegal}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
